// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the two writeback requesters, the register file write
// port and the register file read-port hazard lookup.
interface regfile_write_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          AValid;
  logic          AReady;
  logic [AW-1:0] AAddr;
  logic [DW-1:0] AData;
  logic          BValid;
  logic          BReady;
  logic [AW-1:0] BAddr;
  logic [DW-1:0] BData;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic          RegWrite;
  logic [AW-1:0] ReadRegister1;
  logic [AW-1:0] ReadRegister2;
  logic          Hazard1;
  logic          Hazard2;
  logic          Grant;

  // Requesters / register file side
  modport master (
    output AValid, AAddr, AData, BValid, BAddr, BData, ReadRegister1, ReadRegister2,
    input  AReady, BReady, WriteRegister, WriteData, RegWrite, Hazard1, Hazard2, Grant
  );

  // Arbiter side
  modport slave (
    input  AValid, AAddr, AData, BValid, BAddr, BData, ReadRegister1, ReadRegister2,
    output AReady, BReady, WriteRegister, WriteData, RegWrite, Hazard1, Hazard2, Grant
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between two
// FIFO-buffered writeback requesters, with read-after-write hazard flags.
//
// Arbitration state (last grant):
//   state  | meaning
//   LAST_A | A was granted most recently; B wins the next tie
//   LAST_B | B was granted most recently (reset); A wins the next tie
module regfile_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                    Clk,
  input logic                    Reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;

  entry_t        a_mem [DEPTH];
  entry_t        b_mem [DEPTH];
  logic [PW-1:0] a_wr, a_rd, b_wr, b_rd;
  logic [PW-1:0] a_cnt, b_cnt;
  logic          a_full, a_empty, b_full, b_empty;
  logic          a_push, b_push, pop_a, pop_b;
  logic [DEPTH-1:0] a_live, b_live;
  last_t         last_q, last_d;
  logic          rw_q, grant_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          hit1, hit2;

  assign a_cnt   = a_wr - a_rd;
  assign b_cnt   = b_wr - b_rd;
  assign a_empty = (a_wr == a_rd);
  assign b_empty = (b_wr == b_rd);
  assign a_full  = (a_wr[IW] != a_rd[IW]) && (a_wr[IW-1:0] == a_rd[IW-1:0]);
  assign b_full  = (b_wr[IW] != b_rd[IW]) && (b_wr[IW-1:0] == b_rd[IW-1:0]);

  // Ready comes from registered fullness only, so a same-cycle pop never frees a slot early.
  assign bus.AReady = !Reset && !a_full;
  assign bus.BReady = !Reset && !b_full;

  // Writes to r0 complete the handshake but are dropped here.
  assign a_push = bus.AValid && bus.AReady && (bus.AAddr != '0);
  assign b_push = bus.BValid && bus.BReady && (bus.BAddr != '0);

  // Last-grant register.
  always_ff @(posedge Clk) begin
    if (Reset) last_q <= LAST_B;
    else       last_q <= last_d;
  end

  // Round-robin pop selection from the pre-edge FIFO state.
  always_comb begin
    pop_a  = 1'b0;
    pop_b  = 1'b0;
    last_d = last_q;
    if (!a_empty && (b_empty || last_q == LAST_B)) begin
      pop_a  = 1'b1;
      last_d = LAST_A;
    end else if (!b_empty) begin
      pop_b  = 1'b1;
      last_d = LAST_B;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge Clk) begin
    if (a_push) a_mem[a_wr[IW-1:0]] <= '{addr: bus.AAddr, data: bus.AData};
    if (b_push) b_mem[b_wr[IW-1:0]] <= '{addr: bus.BAddr, data: bus.BData};
  end

  // FIFO pointers with wrap bit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_wr <= '0;
      a_rd <= '0;
      b_wr <= '0;
      b_rd <= '0;
    end else begin
      if (a_push) a_wr <= a_wr + PW'(1);
      if (pop_a)  a_rd <= a_rd + PW'(1);
      if (b_push) b_wr <= b_wr + PW'(1);
      if (pop_b)  b_rd <= b_rd + PW'(1);
    end
  end

  // Registered write port: one cycle of RegWrite per popped entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rw_q    <= 1'b0;
      grant_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (pop_a) begin
      rw_q    <= 1'b1;
      grant_q <= 1'b0;
      waddr_q <= a_mem[a_rd[IW-1:0]].addr;
      wdata_q <= a_mem[a_rd[IW-1:0]].data;
    end else if (pop_b) begin
      rw_q    <= 1'b1;
      grant_q <= 1'b1;
      waddr_q <= b_mem[b_rd[IW-1:0]].addr;
      wdata_q <= b_mem[b_rd[IW-1:0]].data;
    end else begin
      rw_q    <= 1'b0;
    end
  end

  assign bus.RegWrite      = rw_q;
  assign bus.Grant         = grant_q;
  assign bus.WriteRegister = waddr_q;
  assign bus.WriteData     = wdata_q;

  // Mark occupied slots: slot i is live when its distance from the read index is below the count.
  always_comb begin
    a_live = '0;
    b_live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a_live[i] = {1'b0, IW'(IW'(i) - a_rd[IW-1:0])} < a_cnt;
      b_live[i] = {1'b0, IW'(IW'(i) - b_rd[IW-1:0])} < b_cnt;
    end
  end

  // Hazard lookup over every queued entry plus the write currently on the port.
  always_comb begin
    hit1 = rw_q && (waddr_q == bus.ReadRegister1);
    hit2 = rw_q && (waddr_q == bus.ReadRegister2);
    for (int i = 0; i < DEPTH; i++) begin
      if (a_live[i] && a_mem[i].addr == bus.ReadRegister1) hit1 = 1'b1;
      if (b_live[i] && b_mem[i].addr == bus.ReadRegister1) hit1 = 1'b1;
      if (a_live[i] && a_mem[i].addr == bus.ReadRegister2) hit2 = 1'b1;
      if (b_live[i] && b_mem[i].addr == bus.ReadRegister2) hit2 = 1'b1;
    end
  end

  assign bus.Hazard1 = (bus.ReadRegister1 != '0) && hit1;
  assign bus.Hazard2 = (bus.ReadRegister2 != '0) && hit2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model, scoreboard
// of expected register file writes, and a negedge monitor.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          grant;
  } wr_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  regfile_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  req_t a_stim[$], b_stim[$];
  req_t mqa[$], mqb[$];
  wr_t  sb[$];
  logic m_last = 1'b1;
  logic m_rw = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] model_rf [32];
  logic [DW-1:0] tb_rf [32];
  int passed = 0;
  int total = 0;
  bit chk_en = 0;
  int phase = 0;
  bit a_low_seen, b_low_seen;
  bit acc_a, acc_b;
  int valid_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic model_hazard(input logic [AW-1:0] r);
    if (r == '0) return 1'b0;
    foreach (mqa[i]) if (mqa[i].addr == r) return 1'b1;
    foreach (mqb[i]) if (mqb[i].addr == r) return 1'b1;
    return m_rw && (m_wa == r);
  endfunction

  // Reference model: arbitration decided from queue sizes before the edge.
  initial forever begin : model
    req_t e;
    bit ra, rb, pa, pb;
    @(posedge Clk);
    if (Reset) begin
      mqa.delete();
      mqb.delete();
      m_last = 1'b1;
      m_rw = 1'b0;
      m_wa = '0;
    end else begin
      ra = mqa.size() < DEPTH;
      rb = mqb.size() < DEPTH;
      pa = (mqa.size() > 0) && (mqb.size() == 0 || m_last);
      pb = !pa && (mqb.size() > 0);
      m_rw = 1'b0;
      if (pa || pb) begin
        e = pa ? mqa.pop_front() : mqb.pop_front();
        m_last = pb;
        m_rw = 1'b1;
        m_wa = e.addr;
        sb.push_back('{addr: e.addr, data: e.data, grant: pb});
        model_rf[e.addr] = e.data;
      end
      if (bus.AValid && ra && bus.AAddr != '0) mqa.push_back('{addr: bus.AAddr, data: bus.AData});
      if (bus.BValid && rb && bus.BAddr != '0) mqb.push_back('{addr: bus.BAddr, data: bus.BData});
    end
  end

  // Register file driven by the DUT write port.
  initial forever begin
    @(posedge Clk);
    if (bus.RegWrite === 1'b1) tb_rf[bus.WriteRegister] = bus.WriteData;
  end

  // Monitor: pop the scoreboard whenever a write is presented.
  initial forever begin : monitor
    wr_t w;
    @(negedge Clk);
    if (chk_en) begin
      check("regwrite", bus.RegWrite, m_rw);
      if (bus.RegWrite === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got r%0d=%0h, expected no write at %0t",
                   bus.WriteRegister, bus.WriteData, $time);
        end else begin
          w = sb.pop_front();
          check("waddr", bus.WriteRegister, w.addr);
          check("wdata", bus.WriteData, w.data);
          check("grant", bus.Grant, w.grant);
        end
      end
      check("aready", bus.AReady, !Reset && mqa.size() < DEPTH);
      check("bready", bus.BReady, !Reset && mqb.size() < DEPTH);
      check("hazard1", bus.Hazard1, model_hazard(bus.ReadRegister1));
      check("hazard2", bus.Hazard2, model_hazard(bus.ReadRegister2));
      if (phase == 3) begin
        if (bus.AReady === 1'b0) a_low_seen = 1;
        if (bus.BReady === 1'b0) b_low_seen = 1;
      end
    end
  end

  task automatic drive();
    bus.AValid = (a_stim.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    bus.BValid = (b_stim.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    if (a_stim.size() > 0) begin
      bus.AAddr = a_stim[0].addr;
      bus.AData = a_stim[0].data;
    end
    if (b_stim.size() > 0) begin
      bus.BAddr = b_stim[0].addr;
      bus.BData = b_stim[0].data;
    end
  endtask

  task automatic step();
    @(negedge Clk);
    acc_a = bus.AValid && bus.AReady;
    acc_b = bus.BValid && bus.BReady;
    @(posedge Clk);
    #2;
    if (acc_a && a_stim.size() > 0) void'(a_stim.pop_front());
    if (acc_b && b_stim.size() > 0) void'(b_stim.pop_front());
    drive();
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    a_stim.delete();
    b_stim.delete();
    drive();
    repeat (n) step();
    Reset = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((a_stim.size() > 0 || b_stim.size() > 0 || mqa.size() > 0 || mqb.size() > 0 || m_rw)
           && k < 200) begin
      step();
      k++;
    end
    if (k == 200) begin
      total++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", k);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      tb_rf[i] = '0;
    end
    bus.AValid = 0; bus.AAddr = '0; bus.AData = '0;
    bus.BValid = 0; bus.BAddr = '0; bus.BData = '0;
    bus.ReadRegister1 = '0; bus.ReadRegister2 = '0;

    do_reset(2);
    chk_en = 1;

    // Single write from A
    a_stim.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    drive();
    wait_idle();
    check("t1_r5", tb_rf[5], 32'hDEADBEEF);

    // Both requesters, three entries each, starting on the same edge
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      a_stim.push_back('{addr: AW'(i + 1), data: DW'(10 + i)});
      b_stim.push_back('{addr: AW'(i + 4), data: DW'(20 + i)});
    end
    drive();
    wait_idle();
    check("t2_r1", tb_rf[1], 10);
    check("t2_r6", tb_rf[6], 22);

    // Saturated streaming with back-pressure
    phase = 3;
    a_low_seen = 0;
    b_low_seen = 0;
    for (int i = 0; i < 8; i++) begin
      a_stim.push_back('{addr: AW'($urandom_range(10, 31)), data: $urandom});
      b_stim.push_back('{addr: AW'($urandom_range(10, 31)), data: $urandom});
    end
    drive();
    wait_idle();
    phase = 0;
    check("t3_a_backpressure", a_low_seen, 1);
    check("t3_b_backpressure", b_low_seen, 1);

    // Write to r0 is dropped
    bus.ReadRegister1 = '0;
    a_stim.push_back('{addr: 5'd0, data: 32'd3});
    drive();
    wait_idle();
    check("t4_r0", tb_rf[0], 0);

    // Hazard window for r2
    bus.ReadRegister1 = 5'd2;
    bus.ReadRegister2 = 5'd4;
    a_stim.push_back('{addr: 5'd2, data: 32'd42});
    drive();
    wait_idle();
    check("t5_r2", tb_rf[2], 42);

    // Reset while r8/r9 are still queued
    do_reset(1);
    bus.ReadRegister1 = 5'd8;
    for (int i = 0; i < 3; i++) a_stim.push_back('{addr: AW'(7 + i), data: DW'(1 + i)});
    drive();
    begin
      int k = 0;
      step();
      while (!acc_a && k < 10) begin
        step();
        k++;
      end
      if (k == 10) begin
        total++;
        $display("FAIL t6_accept_timeout: r7 not accepted, required acceptance");
      end
    end
    step();
    Reset = 1'b1;
    a_stim.delete();
    drive();
    step();
    Reset = 1'b0;
    repeat (4) step();
    check("t6_r7", tb_rf[7], 1);
    check("t6_r8", tb_rf[8], 0);
    check("t6_r9", tb_rf[9], 0);

    // Random traffic with one reset pulse
    valid_pct = 70;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (a_stim.size() < 3 && $urandom_range(0, 99) < 50)
        a_stim.push_back('{addr: AW'($urandom_range(0, 31)), data: $urandom});
      if (b_stim.size() < 3 && $urandom_range(0, 99) < 50)
        b_stim.push_back('{addr: AW'($urandom_range(0, 31)), data: $urandom});
      bus.ReadRegister1 = AW'($urandom_range(0, 31));
      bus.ReadRegister2 = AW'($urandom_range(0, 31));
      if (cyc == 200) begin
        Reset = 1'b1;
        a_stim.delete();
        b_stim.delete();
        drive();
        step();
        Reset = 1'b0;
      end
      drive();
      step();
    end
    valid_pct = 100;
    wait_idle();
    step();

    for (int i = 0; i < 32; i++) check($sformatf("rf_r%0d", i), tb_rf[i], model_rf[i]);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (WriteRegister/WriteData/RegWrite) between two writeback requesters, A and B. Each requester has a valid/ready handshake. Accepted writes are held in a per-requester FIFO. The arbiter drains the FIFOs onto the register file one write per cycle, using round-robin arbitration. It also reports read-after-write hazards for the register file's two read ports, so the consumer can stall until a pending write has landed.

Parameters:
DEPTH, 4, entries per requester FIFO; power of 2, minimum 2
AW, 5, register address width (32 registers)
DW, 32, data width

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
AValid  input  1  requester A has a write
AReady  output  1  A FIFO can accept
AAddr  input  AW  A destination register
AData  input  DW  A write data
BValid  input  1  requester B has a write
BReady  output  1  B FIFO can accept
BAddr  input  AW  B destination register
BData  input  DW  B write data
WriteRegister  output  AW  to register file write address
WriteData  output  DW  to register file write data
RegWrite  output  1  to register file write enable
ReadRegister1  input  AW  address currently presented on read port 1
ReadRegister2  input  AW  address currently presented on read port 2
Hazard1  output  1  pending write to ReadRegister1
Hazard2  output  1  pending write to ReadRegister2
Grant  output  1  source of current RegWrite: 0=A, 1=B

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; it is sampled only on posedge Clk.
- Reset values: both FIFOs empty; RegWrite=0, WriteRegister=0, WriteData=0, Grant=0; internal last-grant=B, so A wins the first tie.
- AReady/BReady:
  - Low while Reset is high.
  - Otherwise AReady = !A_full (same for B).
  - Depends only on registered state, never on AValid/BValid or on a same-cycle pop. A full FIFO stays not-ready for that cycle even if it is popped.
- Accept: a handshake completes when AValid && AReady at posedge.
  - AAddr != 0: {AAddr, AData} is pushed to the A FIFO.
  - AAddr == 0: the handshake completes but the entry is discarded; it never produces a RegWrite. Register 0 is constant zero.
  - B behaves identically.
- No bypass: an entry pushed at edge N is first eligible for pop at edge N+1.
- Arbitration, evaluated on FIFO state before the edge:
  - Only A nonempty: pop A.
  - Only B nonempty: pop B.
  - Both nonempty: pop the requester not granted last; update last-grant.
  - Neither nonempty: no pop.
- Output register:
  - On a pop at edge N: WriteRegister, WriteData and Grant are loaded from the popped entry, and RegWrite=1 during cycle N..N+1. The register file commits at edge N+1.
  - With no pop, RegWrite=0 and WriteRegister/WriteData/Grant hold their previous values.
  - Minimum latency: accepted at edge N, RegWrite high in cycle N+1, register file updated at edge N+2.
- Ordering: strict FIFO order within each requester. Across requesters, order follows round-robin. Two writes to the same register from different requesters commit in grant order.
- Throughput: one write per cycle sustained. With both requesters saturated, each gets every other cycle.
- FIFO pointers: log2(DEPTH)+1 bits with wrap bit. Full = same index with wrap bits differing; empty = pointers equal. Simultaneous push and pop on a nonempty, non-full FIFO keeps the count unchanged.
- Hazards (combinational):
  - Hazard1 = (ReadRegister1 != 0) && (ReadRegister1 matches any valid entry in either FIFO, or RegWrite && WriteRegister == ReadRegister1).
  - Hazard2 is the same for ReadRegister2.
  - Hazard drops in the cycle after the last matching RegWrite cycle.
- Reset mid-operation: all queued entries are discarded and the in-flight output is cleared. In the cycle after the reset edge, RegWrite=0, Hazard1/Hazard2=0, and AReady/BReady=1 once Reset is low.

Test Plan:
1. After reset, A sends (5, 32'hDEADBEEF) accepted at edge N -> RegWrite=1 only in cycle N+1 with WriteRegister=5, WriteData=DEADBEEF, Grant=0; register file read of r5 returns DEADBEEF after edge N+2.
2. A and B both push 3 entries (A: r1..r3 data 10..12, B: r4..r6 data 20..22), valid from the same edge -> RegWrite high 6 consecutive cycles; Grant sequence 0,1,0,1,0,1; addresses 1,4,2,5,3,6.
3. A and B both stream 8 writes back-to-back, DEPTH=4 -> AReady and BReady each go low at least once; all 16 writes appear exactly once; per-requester FIFO order preserved; no RegWrite gap while either FIFO is nonempty.
4. A sends (0, 3) -> handshake completes, RegWrite never asserts; ReadRegister1=0 gives Hazard1=0; reading r0 returns 0.
5. A sends (2, 42) with ReadRegister1=2, ReadRegister2=4 -> Hazard1=1 from the cycle after acceptance through the RegWrite cycle, 0 afterwards; Hazard2 stays 0; r2 reads 42 once Hazard1 drops.
6. A queues r7, r8, r9 (data 1, 2, 3); Reset is asserted for one cycle right after the r7 RegWrite cycle -> no RegWrite for r8/r9; Hazard1/Hazard2=0 (ReadRegister1=8); AReady=1 the cycle after Reset deasserts; r8 and r9 are not written.
